// File: rtl/pll_sequencer_if.sv
// rtl/pll_sequencer_if.sv - control/status bundle between a PLL sequencer and its user
//
// Purpose: groups the sequencing request, raw PLL lock and all sequencer outputs.
// Signals:
//   enable      - sequencing request, synchronous to clk
//   locked      - raw PLL lock indication, asynchronous
//   pll_resetn  - PLL RESETB drive, 0 holds the PLL in reset
//   sys_reset   - active-high reset for the PLL output domain
//   ready       - PLL locked, stable and released
//   fault       - retries exhausted
//   retry_count - failed lock attempts in the current sequence
//   lol_count   - saturating loss-of-lock events seen in RUN
//   state       - current sequencer state code
// Modports: master drives enable/locked, slave (the sequencer) drives the rest.

interface pll_sequencer_if;
   logic       enable;
   logic       locked;
   logic       pll_resetn;
   logic       sys_reset;
   logic       ready;
   logic       fault;
   logic [3:0] retry_count;
   logic [7:0] lol_count;
   logic [2:0] state;

   modport master (
      output enable, locked,
      input  pll_resetn, sys_reset, ready, fault, retry_count, lol_count, state
   );

   modport slave (
      input  enable, locked,
      output pll_resetn, sys_reset, ready, fault, retry_count, lol_count, state
   );
endinterface

// File: rtl/pll_sequencer.sv
// rtl/pll_sequencer.sv - PLL reset, lock-wait, stabilisation and release sequencer
//
// Purpose: holds the PLL in reset, waits for lock with a timeout and bounded
// retries, requires a stable lock window before releasing the output domain,
// and restarts the PLL on loss of lock while counting such events.
// Ports:
//   clk   - PLL reference clock, sole clock
//   reset - asynchronous active-high reset
//   bus   - pll_sequencer_if slave: enable/locked in, status and controls out

module pll_sequencer #(
   parameter int RESET_CYCLES  = 16,
   parameter int LOCK_TIMEOUT  = 65535,
   parameter int STABLE_CYCLES = 1024,
   parameter int MAX_RETRIES   = 3
) (
   input logic            clk,
   input logic            reset,
   pll_sequencer_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      PLL_RST   = 3'd1,
      WAIT_LOCK = 3'd2,
      STABLE    = 3'd3,
      RUN       = 3'd4,
      FAULT     = 3'd5
   } state_t;

   // Counter values on the last cycle of each timed state (counter starts at 0 on entry).
   localparam logic [31:0] RST_LAST     = 32'(RESET_CYCLES - 1);
   localparam logic [31:0] TIMEOUT_LAST = 32'(LOCK_TIMEOUT - 1);
   localparam logic [31:0] STABLE_LAST  = 32'(STABLE_CYCLES - 1);
   localparam logic [3:0]  RETRY_LIMIT  = 4'(MAX_RETRIES);

   logic        sync1_q, sync2_q;
   logic        locked_s;
   state_t      state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   logic [3:0]  retry_q, retry_d;
   logic [3:0]  retry_inc;
   logic [7:0]  lol_q, lol_d;

   assign locked_s = sync2_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         state_q <= IDLE;
         cnt_q   <= '0;
         retry_q <= '0;
         lol_q   <= '0;
      end else begin
         sync1_q <= bus.locked;
         sync2_q <= sync1_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         retry_q <= retry_d;
         lol_q   <= lol_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      retry_d   = retry_q;
      lol_d     = lol_q;
      retry_inc = retry_q + 4'd1;

      if (!bus.enable) begin
         state_d = IDLE;
         retry_d = '0;
      end else begin
         case (state_q)
            IDLE: state_d = PLL_RST;
            PLL_RST: begin
               if (cnt_q >= RST_LAST) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
               if (locked_s) begin
                  state_d = STABLE;
               end else if (cnt_q >= TIMEOUT_LAST) begin
                  retry_d = retry_inc;
                  state_d = (retry_inc < RETRY_LIMIT) ? PLL_RST : FAULT;
               end
            end
            STABLE: begin
               // A single unlocked cycle restarts the lock wait without costing a retry.
               if (!locked_s) begin
                  state_d = WAIT_LOCK;
               end else if (cnt_q >= STABLE_LAST) begin
                  state_d = RUN;
                  retry_d = '0;
               end
            end
            RUN: begin
               if (!locked_s) begin
                  state_d = PLL_RST;
                  if (lol_q != 8'hFF) lol_d = lol_q + 8'd1;
               end
            end
            FAULT: state_d = FAULT;
            default: state_d = IDLE;
         endcase
      end

      // Counter restarts on every state change and saturates instead of wrapping.
      if (!bus.enable || (state_d != state_q)) begin
         cnt_d = '0;
      end else if (cnt_q != 32'hFFFF_FFFF) begin
         cnt_d = cnt_q + 32'd1;
      end else begin
         cnt_d = cnt_q;
      end
   end

   assign bus.pll_resetn  = (state_q == WAIT_LOCK) || (state_q == STABLE) || (state_q == RUN);
   assign bus.sys_reset   = (state_q != RUN);
   assign bus.ready       = (state_q == RUN);
   assign bus.fault       = (state_q == FAULT);
   assign bus.retry_count = retry_q;
   assign bus.lol_count   = lol_q;
   assign bus.state       = state_q;

endmodule

// File: tb/tb_pll_sequencer.sv
// tb/tb_pll_sequencer.sv - self-checking bench for pll_sequencer

module tb_pll_sequencer;

   localparam int RC = 4;
   localparam int LT = 20;
   localparam int SC = 8;
   localparam int MR = 2;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;

   pll_sequencer_if bus ();

   pll_sequencer #(
      .RESET_CYCLES (RC),
      .LOCK_TIMEOUT (LT),
      .STABLE_CYCLES(SC),
      .MAX_RETRIES  (MR)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // Reference model: timestamps of state entry and a delay queue for the synchronizer.
   int m_state, m_entry, m_retry, m_lol, cyc;
   bit hist[$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at t=%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
      end
   endtask

   task automatic model_reset();
      m_state = 0;
      m_retry = 0;
      m_lol   = 0;
      cyc     = 0;
      m_entry = 0;
      hist    = {1'b0, 1'b0};
   endtask

   task automatic model_edge(input bit en, input bit lk);
      bit ls;
      int nxt;
      int spent;
      ls = hist.pop_front();
      hist.push_back(lk);
      spent = cyc - m_entry + 1;
      nxt = m_state;
      if (!en) begin
         nxt = 0;
         m_retry = 0;
      end else begin
         case (m_state)
            0: nxt = 1;
            1: if (spent >= RC) nxt = 2;
            2: begin
               if (ls) nxt = 3;
               else if (spent >= LT) begin
                  m_retry++;
                  nxt = (m_retry < MR) ? 1 : 5;
               end
            end
            3: begin
               if (!ls) nxt = 2;
               else if (spent >= SC) begin
                  nxt = 4;
                  m_retry = 0;
               end
            end
            4: if (!ls) begin
               nxt = 1;
               if (m_lol < 255) m_lol++;
            end
            default: nxt = m_state;
         endcase
      end
      if (nxt != m_state) m_entry = cyc + 1;
      m_state = nxt;
      cyc++;
   endtask

   function automatic logic [31:0] model_vec();
      bit pr, sr, rd, ft;
      pr = (m_state == 2) || (m_state == 3) || (m_state == 4);
      sr = (m_state != 4);
      rd = (m_state == 4);
      ft = (m_state == 5);
      return {13'd0, 3'(m_state), pr, sr, rd, ft, 4'(m_retry), 8'(m_lol)};
   endfunction

   function automatic logic [31:0] dut_vec();
      return {13'd0, bus.state, bus.pll_resetn, bus.sys_reset, bus.ready, bus.fault,
              bus.retry_count, bus.lol_count};
   endfunction

   localparam logic [31:0] RST_VEC = {13'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0};

   task automatic set_in(input bit en, input bit lk);
      bus.enable = en;
      bus.locked = lk;
   endtask

   task automatic step();
      @(posedge clk);
      model_edge(bus.enable, bus.locked);
      #1;
      check_eq($sformatf("cycle_%0d", cyc), dut_vec(), model_vec());
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      #1;
      check_eq("reset_pulse_outputs", dut_vec(), RST_VEC);
      model_reset();
      #2;
      reset = 1'b0;
   endtask

   initial begin
      int lseg;
      int eseg;
      bit lk;
      bit en;

      reset = 1'b1;
      set_in(1'b0, 1'b1);
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_eq("reset_outputs", dut_vec(), RST_VEC);
      reset = 1'b0;
      model_reset();

      // Normal bring-up
      set_in(1'b1, 1'b1);
      step();     check_eq("bringup_c1_state", bus.state, 3'd1);
      steps(3);   check_eq("bringup_c4_state", bus.state, 3'd1);
      step();     check_eq("bringup_c5_state", bus.state, 3'd2);
      step();     check_eq("bringup_c6_state", bus.state, 3'd3);
      steps(7);   check_eq("bringup_c13_state", bus.state, 3'd3);
      step();
      check_eq("bringup_c14_state", bus.state, 3'd4);
      check_eq("bringup_ready", bus.ready, 1'b1);
      check_eq("bringup_sys_reset", bus.sys_reset, 1'b0);
      check_eq("bringup_retry", bus.retry_count, 4'd0);

      // Loss of lock in RUN
      set_in(1'b1, 1'b0);
      step();
      set_in(1'b1, 1'b1);
      step();     check_eq("lol_still_run", bus.state, 3'd4);
      step();
      check_eq("lol_state", bus.state, 3'd1);
      check_eq("lol_sys_reset", bus.sys_reset, 1'b1);
      check_eq("lol_count", bus.lol_count, 8'd1);
      steps(12);  check_eq("lol_regain_stable", bus.state, 3'd3);
      step();     check_eq("lol_regain_run", bus.state, 3'd4);

      // Lock glitch during STABLE
      set_in(1'b0, 1'b1);
      step();     check_eq("disable_from_run", bus.state, 3'd0);
      set_in(1'b1, 1'b1);
      steps(7);   check_eq("glitch_pre_stable", bus.state, 3'd3);
      set_in(1'b1, 1'b0);
      step();
      set_in(1'b1, 1'b1);
      steps(2);
      check_eq("glitch_wait_lock", bus.state, 3'd2);
      check_eq("glitch_retry", bus.retry_count, 4'd0);
      steps(8);   check_eq("glitch_fresh_stable", bus.state, 3'd3);
      step();     check_eq("glitch_run", bus.state, 3'd4);

      // Disable in STABLE
      set_in(1'b0, 1'b1);
      step();
      set_in(1'b1, 1'b1);
      steps(6);   check_eq("dis_pre_stable", bus.state, 3'd3);
      set_in(1'b0, 1'b1);
      step();     check_eq("dis_idle", bus.state, 3'd0);

      // Timeout to FAULT
      set_in(1'b1, 1'b0);
      steps(24);  check_eq("to_wait1_end", bus.state, 3'd2);
      step();
      check_eq("to_retry1_state", bus.state, 3'd1);
      check_eq("to_retry1_count", bus.retry_count, 4'd1);
      steps(23);  check_eq("to_wait2_end", bus.state, 3'd2);
      step();
      check_eq("to_fault_state", bus.state, 3'd5);
      check_eq("to_fault_flag", bus.fault, 1'b1);
      check_eq("to_fault_pll_resetn", bus.pll_resetn, 1'b0);
      check_eq("to_fault_sys_reset", bus.sys_reset, 1'b1);
      check_eq("to_fault_retry", bus.retry_count, 4'd2);
      steps(5);   check_eq("to_fault_hold", bus.state, 3'd5);

      // Reset pulse in RUN
      set_in(1'b0, 1'b1);
      step();
      set_in(1'b1, 1'b1);
      steps(14);
      check_eq("rst_pre_run", bus.state, 3'd4);
      check_eq("rst_pre_lol", bus.lol_count, 8'd1);
      pulse_reset();
      check_eq("rst_lol_cleared", bus.lol_count, 8'd0);
      step();     check_eq("rst_restart", bus.state, 3'd1);

      // Randomized traffic against the model
      lseg = 0;
      eseg = 0;
      lk   = 1'b1;
      for (int i = 0; i < 4000; i++) begin
         if (lseg == 0) begin
            lk   = ($urandom_range(0, 3) != 0);
            lseg = lk ? int'($urandom_range(1, 60)) : int'($urandom_range(1, 50));
         end
         lseg--;
         en = 1'b1;
         if ((eseg == 0) && ($urandom_range(0, 199) == 0)) eseg = int'($urandom_range(1, 3));
         if (eseg > 0) begin
            en = 1'b0;
            eseg--;
         end
         set_in(en, lk);
         step();
         if ($urandom_range(0, 599) == 0) pulse_reset();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pll_sequencer.md
PLL_SEQUENCER -- requirements
Module: pll_sequencer

Interface
REQ-001 SHALL have parameter RESET_CYCLES, default 16: cycles the PLL is held in reset per attempt, at least 1.
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 65535: cycles allowed in WAIT_LOCK before an attempt is declared failed, at least 1.
REQ-003 SHALL have parameter STABLE_CYCLES, default 1024: consecutive synchronized-lock cycles required before release, at least 1.
REQ-004 SHALL have parameter MAX_RETRIES, default 3: failed attempts tolerated before FAULT, 1..15.
REQ-005 SHALL have port clk, input, 1 bit: PLL reference clock, which is the sole clock.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port enable, input, 1 bit: sequencing request, synchronous to clk.
REQ-008 SHALL have port locked, input, 1 bit: PLL lock indication, asynchronous.
REQ-009 SHALL have port pll_resetn, output, 1 bit: drives the PLL RESETB input; 0 holds the PLL in reset.
REQ-010 SHALL have port sys_reset, output, 1 bit: active-high reset for logic in the PLL output domain.
REQ-011 SHALL have port ready, output, 1 bit: PLL locked, stable and released.
REQ-012 SHALL have port fault, output, 1 bit: retries exhausted.
REQ-013 SHALL have port retry_count, output, 4 bits: failed attempts in the current sequence.
REQ-014 SHALL have port lol_count, output, 8 bits: loss-of-lock events seen in RUN, saturating.
REQ-015 SHALL have port state, output, 3 bits: current state encoding.

Function
REQ-016 SHALL pass locked through a 2-flop synchronizer to form locked_s; all decisions use locked_s only, adding 2 cycles of latency.
REQ-017 SHALL implement the states and encodings IDLE=0, PLL_RST=1, WAIT_LOCK=2, STABLE=3, RUN=4, FAULT=5; codes 6 and 7 SHALL go to IDLE on the next cycle.
REQ-018 SHALL decode all outputs from registered state and registered counters only, with no combinational path from any input to any output.
REQ-019 SHALL drive pll_resetn=1 only in WAIT_LOCK, STABLE and RUN; sys_reset=0 and ready=1 only in RUN; fault=1 only in FAULT.
REQ-020 SHALL, whenever enable=0, go to IDLE on the next cycle from any state, with priority over every other transition, clearing retry_count and the cycle counter.
REQ-021 SHALL, in IDLE with enable=1, go to PLL_RST on the next cycle.
REQ-022 SHALL remain in PLL_RST for exactly RESET_CYCLES cycles and then go to WAIT_LOCK.
REQ-023 SHALL, in WAIT_LOCK with locked_s=1, go to STABLE on the next cycle; if LOCK_TIMEOUT cycles elapse without locked_s, it SHALL handle the failure per REQ-024.
REQ-024 SHALL, on a timeout, increment retry_count; if the new value is below MAX_RETRIES it SHALL go to PLL_RST, otherwise it SHALL go to FAULT.
REQ-025 SHALL, in STABLE, go to RUN after STABLE_CYCLES consecutive cycles with locked_s=1; any cycle with locked_s=0 SHALL return it to WAIT_LOCK with a fresh timeout and no retry increment.
REQ-026 SHALL, on entry to RUN, clear retry_count.
REQ-027 SHALL, in RUN with locked_s=0, go to PLL_RST and increment lol_count, saturating at 255; sys_reset SHALL assert in the same cycle that PLL_RST is entered.
REQ-028 SHALL hold FAULT until enable=0; lol_count SHALL be cleared only by reset.
REQ-029 SHALL use a 32-bit cycle counter, cleared on every state change; no parameter value SHALL cause wrap-around within a state.

Reset
REQ-030 SHALL, while reset=1, asynchronously force state=IDLE, counters=0, synchronizer=0, pll_resetn=0, sys_reset=1, ready=0 and fault=0.
REQ-031 SHALL, on reset deassertion, run the first transition on the next clk edge; reset asserted mid-sequence SHALL abandon the sequence immediately.

Verification
Parameters for all scenarios: RESET_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2, locked high from before reset release.
REQ-032 SHALL cover normal bring-up: enable rises at cycle 0 -> PLL_RST cycles 1-4, WAIT_LOCK at 5, STABLE at 6-13, RUN at 14 with ready=1, sys_reset=0, retry_count=0.
REQ-033 SHALL cover timeout to fault: locked held 0 -> two WAIT_LOCK periods of 20 cycles each, retry_count 1 then 2, then FAULT with fault=1, pll_resetn=0, sys_reset=1.
REQ-034 SHALL cover a lock glitch: locked drops for 1 cycle during STABLE -> state returns to WAIT_LOCK, retry_count unchanged, RUN reached only after 8 fresh consecutive locked_s cycles.
REQ-035 SHALL cover loss of lock in RUN: locked drops -> 2 cycles later PLL_RST with sys_reset=1 and lol_count=1; RUN regained after 4+1+8 further cycles.
REQ-036 SHALL cover disable and reset priority: enable=0 in STABLE -> IDLE next cycle; reset pulsed in RUN -> immediate IDLE, all outputs at reset values, lol_count=0.
